// File: rtl/serial_pkg.sv
// Shared state encoding, line levels and frame-length helper for the serial transmitter.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Serial bits per frame: start + payload + optional parity + stop.
  function automatic int frame_bits(input int data_width, input bit parity_en);
    return data_width + (parity_en ? 3 : 2);
  endfunction

endpackage

// File: rtl/serial_frame_tx_baud_tick_gen.sv
// Bit-period timer: free-running 0..CLKS_PER_BIT-1 counter with synchronous clear,
// tick is high during the last cycle of each bit period.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, payload LSB-first, optional even parity, stop bit.
// Parity is compiled in only when SERIAL_TX_PARITY_EN is defined.
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  tx,
  output logic                  done
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tx_q, tx_d;
  logic                  tick;
  logic                  accept;

  assign accept = valid && (state_q == IDLE);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear_i(accept),
    .tick_o (tick)
  );

`ifdef SERIAL_TX_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (accept) begin
      par_d = ^data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  // tx_d is the line level for the next cycle, so tx stays a clean register output.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    ready   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        tx_d  = LINE_IDLE;
        if (valid) begin
          state_d = START;
          shreg_d = data;
          tx_d    = START_BIT;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == IDX_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = STOP_BIT;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
            tx_d  = shreg_q[1];
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = STOP_BIT;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          done    = 1'b1;
          state_d = IDLE;
          tx_d    = LINE_IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      tx_q    <= LINE_IDLE;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: scoreboard-driven line monitor plus per-scenario timing checks.
module tb_serial_frame_tx;
  import serial_pkg::*;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FB   = frame_bits(DW, PAR_EN);
  localparam int FLEN = FB * CPB;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid;
  logic [DW-1:0] data;
  logic          ready;
  logic          tx;
  logic          done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] sb_q[$];
  bit            mon_en = 1'b0;
  logic          mon_prev;
  logic [DW-1:0] mon_w;
  logic [FB-1:0] mon_exp;
  bit            mon_okd;
  int            mon_badbits;

  serial_frame_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .data (data),
    .valid(valid),
    .ready(ready),
    .tx   (tx),
    .done (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: every falling edge on tx starts a frame, checked against the next expected word.
  initial begin : monitor
    mon_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && mon_prev === 1'b1 && tx === 1'b0) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_frame at cyc=%0d queue_size=0 want frame-free line", cyc);
          mon_w = '0;
        end else begin
          mon_w = sb_q.pop_front();
        end
        mon_exp[0] = 1'b0;
        for (int i = 0; i < DW; i++) mon_exp[1+i] = mon_w[i];
        if (PAR_EN) mon_exp[DW+1] = ^mon_w;
        mon_exp[FB-1] = 1'b1;
        mon_okd = 1'b1;
        for (int b = 0; b < FB; b++) begin
          mon_badbits = 0;
          for (int s = 0; s < CPB; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (tx !== mon_exp[b]) mon_badbits++;
            if (done !== ((b == FB-1 && s == CPB-1) ? 1'b1 : 1'b0)) mon_okd = 1'b0;
          end
          total++;
          if (mon_badbits != 0) begin
            bad++;
            $display("FAIL frame_bit%0d word=%h tx=%b in %0d of %0d cycles, want %b",
                     b, mon_w, tx, mon_badbits, CPB, mon_exp[b]);
          end
        end
        total++;
        if (!mon_okd) begin
          bad++;
          $display("FAIL frame_done word=%h done pulse misplaced, want only in last stop cycle", mon_w);
        end
      end
      mon_prev = tx;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog cyc=%0d want bench finished", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [DW-1:0] w, input bit hold, output int acc);
    int n;
    @(negedge clk);
    data  = w;
    valid = 1'b1;
    n     = 0;
    while (ready !== 1'b1 && n < 4*FLEN) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL send_timeout ready=%b want 1", ready);
      valid = 1'b0;
      acc   = -1;
    end else begin
      sb_q.push_back(w);
      @(negedge clk);
      acc = cyc;
      if (!hold) begin
        valid = 1'b0;
        data  = ~w;
      end
    end
  endtask

  task automatic wait_frame_end(output int dstamp);
    dstamp = -1;
    for (int i = 0; i < FLEN + 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dstamp = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    int acc;
    bit saw_done;
    bit quiet;
    reset = 1'b1;
    valid = 1'b0;
    data  = '0;
    repeat (2) @(negedge clk);
    total++; if (tx !== 1'b1)    begin bad++; $display("FAIL reset_tx tx=%b want 1", tx); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready ready=%b want 1", ready); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done done=%b want 0", done); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if (tx !== 1'b1)    begin bad++; $display("FAIL idle_rst_tx tx=%b want 1", tx); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL idle_rst_ready ready=%b want 1", ready); end
    @(negedge clk);
    reset = 1'b0;
    send(8'h00, 1'b0, acc);
    repeat (CPB + 1) @(negedge clk);
    total++; if (tx !== 1'b0)    begin bad++; $display("FAIL pre_rst_tx tx=%b want 0 (data bit0)", tx); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL pre_rst_ready ready=%b want 0", ready); end
    #2 reset = 1'b1;
    #1;
    total++; if (tx !== 1'b1)    begin bad++; $display("FAIL data_rst_tx tx=%b want 1", tx); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL data_rst_ready ready=%b want 1", ready); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL data_rst_done done=%b want 0", done); end
    @(negedge clk);
    reset    = 1'b0;
    saw_done = 1'b0;
    quiet    = 1'b1;
    for (int i = 0; i < FLEN + 8; i++) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
      if (tx !== 1'b1 || ready !== 1'b1) quiet = 1'b0;
    end
    total++; if (saw_done) begin bad++; $display("FAIL rst_no_done saw_done=1 want 0"); end
    total++; if (!quiet)   begin bad++; $display("FAIL rst_line_idle quiet=0 want 1"); end
    sb_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    int acc;
    int dst;
    send(8'hA5, 1'b0, acc);
    total++; if (tx !== 1'b0)    begin bad++; $display("FAIL single_start tx=%b want 0", tx); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL single_busy ready=%b want 0", ready); end
    wait_frame_end(dst);
    total++;
    if (dst < 0 || dst - acc != FLEN - 1) begin
      bad++; $display("FAIL single_done_offset got=%0d want=%0d", dst - acc + 1, FLEN);
    end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL single_done_ready ready=%b want 0", ready); end
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL single_ready_after ready=%b want 1", ready); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL single_done_width done=%b want 0", done); end
  endtask

  task automatic test_parity();
    int acc;
    int dst;
    logic [DW-1:0] words [2];
    words[0] = 8'h07;
    words[1] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      send(words[i], 1'b0, acc);
      wait_frame_end(dst);
      total++;
      if (dst < 0 || dst - acc != FLEN - 1) begin
        bad++; $display("FAIL parity_done_offset word=%h got=%0d want=%0d", words[i], dst - acc + 1, FLEN);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc1;
    int n;
    int dst;
    send(8'h3C, 1'b1, acc1);
    data = 8'hC3;
    n    = 0;
    while (ready !== 1'b1 && n < 2*FLEN) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (cyc - acc1 != FLEN) begin
      bad++; $display("FAIL b2b_ready_cycle got=%0d want=%0d", cyc - acc1, FLEN);
    end
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL b2b_idle_tx tx=%b want 1", tx); end
    if (ready === 1'b1) sb_q.push_back(8'hC3);
    @(negedge clk);
    data  = 8'h00;
    valid = 1'b0;
    total++;
    if (cyc - acc1 != FLEN + 1) begin
      bad++; $display("FAIL b2b_accept_gap got=%0d want=%0d", cyc - acc1, FLEN + 1);
    end
    total++; if (tx !== 1'b0)    begin bad++; $display("FAIL b2b_second_start tx=%b want 0", tx); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL b2b_second_busy ready=%b want 0", ready); end
    wait_frame_end(dst);
    total++;
    if (dst < 0 || dst - acc1 != 2*FLEN) begin
      bad++; $display("FAIL b2b_done_offset got=%0d want=%0d", dst - acc1, 2*FLEN);
    end
  endtask

  task automatic test_busy_ignore();
    int acc;
    int dst;
    bit quiet;
    send(8'h12, 1'b0, acc);
    repeat (3*CPB) @(negedge clk);
    data  = 8'hFF;
    valid = 1'b1;
    @(negedge clk);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL busy_ready ready=%b want 0", ready); end
    @(negedge clk);
    valid = 1'b0;
    data  = '0;
    wait_frame_end(dst);
    total++;
    if (dst < 0 || dst - acc != FLEN - 1) begin
      bad++; $display("FAIL busy_done_offset got=%0d want=%0d", dst - acc + 1, FLEN);
    end
    quiet = 1'b1;
    for (int i = 0; i < FLEN + 5; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || ready !== 1'b1 || done !== 1'b0) quiet = 1'b0;
    end
    total++; if (!quiet) begin bad++; $display("FAIL busy_no_extra quiet=0 want 1"); end
  endtask

  initial begin
    reset = 1'b1;
    valid = 1'b0;
    data  = '0;
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_busy_ignore();
    repeat (4) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain left=%0d want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
